bec_result_serializer: RTL and testbench
========================================

# bec_result_serializer

Downstream stage of the BEC adder wrapper. It captures each 3-bit sum as the adder signals completion and buffers it in a small FIFO. It then shifts each result out on one user I/O pad as a framed serial word, so results can be observed off-chip without the logic analyzer. It also exposes fill level and overflow for LA readback.

## Interface
Parameters:
- `WIDTH`, 3: result width in bits; matches the adder sum.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `BIT_CYCLES`, 4: clock cycles each serial bit is held; must be at least 1.

Ports:
- `wb_clk_i`  in  1: single clock. All state changes on the rising edge.
- `wb_rst_n`  in  1: reset. Asynchronous, active-low.
- `in_valid`  in  1: one-cycle pulse from the adder stage; `in_data` is valid in the same cycle.
- `in_data`  in  WIDTH: sum to capture.
- `clr_ovf`  in  1: synchronous clear of the sticky overflow flag.
- `ser_out`  out  1: serial frame output. Idles high.
- `busy`  out  1: high whenever the frame FSM is not IDLE.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1: sticky. Set when a push is dropped.

## Operation
- Reset values: `ser_out`=1, `busy`=0, `level`=0, `overflow`=0. FSM in IDLE, FIFO pointers 0, counters 0.
- Push: `in_valid` writes `in_data` at the FIFO tail. There is no ready signal; the producer cannot stall.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and sets `overflow`. Contents are unchanged.
  - A push coinciding with a pop is accepted; `level` stays at DEPTH.
- Overflow clear: `clr_ovf` clears `overflow`. If `clr_ovf` and a dropped push occur in the same cycle, set wins.
- Frame format: start bit 0, then WIDTH data bits LSB first, then even-parity bit (XOR of the data bits), then stop bit 1. That is WIDTH+3 bits per frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `level`≠0, pop the head into a shift register and go to START. Otherwise stay.
  - START: hold 0 for BIT_CYCLES, then go to DATA.
  - DATA: output shreg[0] for BIT_CYCLES per bit, shifting right after each bit. After WIDTH bits, go to PARITY.
  - PARITY: hold parity for BIT_CYCLES, then go to STOP.
  - STOP: hold 1 for BIT_CYCLES. On the last cycle, if `level`≠0, pop and go straight to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Counters:
  - Cycle counter counts 0..BIT_CYCLES-1 and wraps at each bit boundary.
  - Bit counter counts 0..WIDTH-1 in DATA only.
- Parity is computed from the popped word at pop time and stored with it.
- Mid-operation reset: asserting `wb_rst_n`=0 aborts any frame. `ser_out` goes to 1 asynchronously and the FIFO is emptied.

## Timing
- `ser_out` is registered.
- Latency: with the FIFO empty and the FSM in IDLE, a push at edge N becomes visible at edge N+1. The pop happens at edge N+1, and `ser_out` falls after edge N+2.
- Frame duration: exactly (WIDTH+3)·BIT_CYCLES cycles, which is 24 at defaults.
- `busy` rises with the START entry and falls with the IDLE entry. It stays high across back-to-back frames.
- `level` is registered:
  - increments the cycle after an accepted push only;
  - decrements the cycle after a pop only;
  - is unchanged when both happen in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Structure
- Shared package `bec_pkg`:
  - frame-state enum constants: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - the BEC result width constant;
  - the frame-length function (WIDTH+3)·BIT_CYCLES.
- Sub-module `bec_result_fifo`: synchronous FIFO with push, pop, full, empty, level and drop-flag outputs.
- The top level of this block holds the frame FSM, counters, shift register and parity.

## Test plan
1. Reset release: `ser_out`=1, `busy`=0, `level`=0, `overflow`=0. Pulse `wb_rst_n` low mid-cycle → outputs return to these values without waiting for a clock edge.
2. Single push, `in_data`=3'b101 at edge N:
   - `ser_out` falls after edge N+2;
   - bit sequence 0,1,0,1,0,1, each held 4 cycles (parity 0);
   - 24 cycles total, then IDLE with `busy`=0.
3. Parity check: `in_data`=3'b100 → data bits 0,0,1, parity bit 1.
4. Back-to-back: push 3'b011, then 3'b110 two cycles later → two contiguous 24-cycle frames with no idle-high gap, and `busy` held high for 48 cycles.
5. Overflow: push 6 values in consecutive cycles while IDLE (one pops after the first edge):
   - `level` peaks at 4;
   - the 6th push is dropped and sets `overflow`;
   - the serialized output carries the first 5 values in order.
   - Then `clr_ovf` → `overflow`=0.
6. Full with simultaneous pop: fill to 4 during a frame, then push on the STOP last cycle → push accepted, `level` stays 4, `overflow` stays 0.

Source files
------------

// File: rtl/bec_pkg.sv
// Shared constants and types for the BEC result path.
package bec_pkg;

  localparam int unsigned BEC_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } frame_state_e;

  // Clock cycles taken by one serial frame: start, data, parity, stop.
  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned bit_cycles);
    return (width + 3) * bit_cycles;
  endfunction

endpackage

// File: rtl/bec_result_fifo.sv
// Small synchronous FIFO; pushes into a full FIFO are dropped unless a pop frees a slot.
module bec_result_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bec_result_serializer.sv
// Buffers adder results and shifts each out as a framed word: start, data LSB first,
// even parity, stop.
module bec_result_serializer
  import bec_pkg::*;
#(
  parameter int unsigned WIDTH      = BEC_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     clr_ovf,
  output logic                     ser_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  frame_state_e     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             ser_q, ser_d;
  logic             ovf_q, ovf_d;
  logic             bit_end;

  logic             fifo_pop, fifo_empty, fifo_drop, unused_fifo_full;
  logic [WIDTH-1:0] fifo_head;

  bec_result_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .level_o (level),
    .drop_o  (fifo_drop)
  );

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    ser_d    = 1'b1;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          par_d    = ^fifo_head;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        ser_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        ser_d = shreg_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = PARITY;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      PARITY: begin
        ser_d = par_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame so queued results leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_head;
            par_d    = ^fifo_head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped push outranks a clear in the same cycle.
  assign ovf_d = fifo_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ser_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ser_out  = ser_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bec_result_serializer.sv
// Self-checking bench for bec_result_serializer against a frame-timeline reference model.
module tb_bec_result_serializer;
  import bec_pkg::*;

  localparam int unsigned W  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned BC = 4;
  localparam int unsigned FL = frame_len(W, BC);

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         clr_ovf;
  logic         ser_out;
  logic         busy;
  logic [2:0]   level;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  bec_result_serializer #(
    .WIDTH      (W),
    .DEPTH      (D),
    .BIT_CYCLES (BC)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_ovf  (clr_ovf),
    .ser_out  (ser_out),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a queue of waiting words plus the frame currently on the wire.
  logic [W-1:0] m_q[$];
  bit           m_active;
  int           m_t;
  logic [W+2:0] m_frame;
  logic         m_ser;
  logic         m_ovf;

  function automatic logic [W+2:0] frame_of(input logic [W-1:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_t      = 0;
    m_frame  = '1;
    m_ser    = 1'b1;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic c);
    bit           pop, full, drop;
    logic         ser_n;
    logic [W-1:0] head;
    pop   = (m_q.size() > 0) && (!m_active || m_t == int'(FL) - 1);
    full  = (m_q.size() == D);
    ser_n = m_active ? m_frame[m_t / int'(BC)] : 1'b1;
    drop  = 0;
    head  = '0;
    if (pop) head = m_q.pop_front();
    if (v) begin
      if (!full || pop) m_q.push_back(d);
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (m_active) begin
      if (m_t == int'(FL) - 1) begin
        if (pop) begin
          m_frame = frame_of(head);
          m_t     = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_t++;
      end
    end else if (pop) begin
      m_active = 1;
      m_t      = 0;
      m_frame  = frame_of(head);
    end
    m_ser = ser_n;
  endtask

  // One clock: drive inputs, advance the model at the edge, return at the falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr_ovf  = c;
    @(posedge wb_clk_i);
    model_edge(v, d, c);
    @(negedge wb_clk_i);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL reset_ser: got %b want 1", ser_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    step(1'b1, 3'b101, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL pre_reset_start: got %b want 0", ser_out); end
    #2 wb_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL async_ser: got %b want 1", ser_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL async_level: got %0d want 0", level); end
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    step(1'b0, 3'b000, 1'b0);
    checks++; if (busy !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b level=%0d want 0/0", busy, level);
    end
  endtask

  task automatic test_single(input string name, input logic [W-1:0] d, input logic [5:0] pat);
    step(1'b1, d, 1'b0);
    checks++; if (level !== 3'd1 || busy !== 1'b0 || ser_out !== 1'b1) begin
      errors++; $display("FAIL %s_push: level=%0d busy=%b ser=%b want 1/0/1", name, level, busy, ser_out);
    end
    step(1'b0, '0, 1'b0);
    checks++; if (level !== 3'd0 || busy !== 1'b1 || ser_out !== 1'b1) begin
      errors++; $display("FAIL %s_pop: level=%0d busy=%b ser=%b want 0/1/1", name, level, busy, ser_out);
    end
    for (int i = 0; i < int'(FL); i++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (ser_out !== pat[i / int'(BC)]) begin
        errors++; $display("FAIL %s_bit[%0d]: got %b want %b", name, i, ser_out, pat[i / int'(BC)]);
      end
      if (i >= int'(FL) - 2) begin
        checks++; if (busy !== (i == int'(FL) - 2)) begin
          errors++; $display("FAIL %s_busy[%0d]: got %b want %b", name, i, busy, i == int'(FL) - 2);
        end
      end
    end
    step(1'b0, '0, 1'b0);
    checks++; if (ser_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle: ser=%b busy=%b want 1/0", name, ser_out, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] f0, f1, pat;
    f0 = 6'b100110;
    f1 = 6'b101100;
    step(1'b1, 3'b011, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 2 * int'(FL); i++) begin
      step(i == 0, 3'b110, 1'b0);
      pat = (i < int'(FL)) ? f0 : f1;
      checks++; if (ser_out !== pat[(i % int'(FL)) / int'(BC)]) begin
        errors++; $display("FAIL b2b_bit[%0d]: got %b want %b", i, ser_out, pat[(i % int'(FL)) / int'(BC)]);
      end
      checks++; if (busy !== (i < 2 * int'(FL) - 1)) begin
        errors++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, busy, i < 2 * int'(FL) - 1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0] lv_exp [6];
    int         peak;
    lv_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    peak   = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, W'($urandom), 1'b0);
      if (int'(level) > peak) peak = int'(level);
      checks++; if (level !== lv_exp[k]) begin
        errors++; $display("FAIL ovf_level[%0d]: got %0d want %0d", k, level, lv_exp[k]);
      end
      checks++; if (overflow !== (k == 5)) begin
        errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, overflow, k == 5);
      end
    end
    checks++; if (peak != 4) begin errors++; $display("FAIL ovf_peak: got %0d want 4", peak); end
    for (int i = 0; i < 5 * int'(FL) + 2; i++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (ser_out !== m_ser || busy !== m_active) begin
        errors++; $display("FAIL ovf_drain[%0d]: ser=%b busy=%b want %b/%b", i, ser_out, busy, m_ser, m_active);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    step(1'b0, '0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 5; k++) step(1'b1, W'(k + 2), 1'b0);
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL fullpop_fill: level=%0d ovf=%b want 4/0", level, overflow);
    end
    for (int k = 0; k < int'(FL) - 4; k++) step(1'b0, '0, 1'b0);
    step(1'b1, 3'b111, 1'b0);
    checks++; if (level !== 3'd4 || overflow !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fullpop_edge: level=%0d ovf=%b busy=%b want 4/0/1", level, overflow, busy);
    end
    for (int i = 0; i < 5 * int'(FL) + 2; i++) begin
      step(1'b0, '0, 1'b0);
      checks++; if (ser_out !== m_ser || level !== 3'(m_q.size())) begin
        errors++; $display("FAIL fullpop_drain[%0d]: ser=%b level=%0d want %b/%0d", i, ser_out, level, m_ser, m_q.size());
      end
    end
    checks++; if (busy !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL fullpop_end: busy=%b level=%0d want 0/0", busy, level);
    end
  endtask

  task automatic test_random();
    logic v, c;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 11) == 0);
      c = ($urandom_range(0, 31) == 0);
      step(v, W'($urandom), c);
      checks++; if (ser_out !== m_ser || busy !== m_active || level !== 3'(m_q.size()) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand[%0d]: ser=%b busy=%b level=%0d ovf=%b want %b/%b/%0d/%b",
                 i, ser_out, busy, level, overflow, m_ser, m_active, m_q.size(), m_ovf);
      end
    end
  endtask

  initial begin
    wb_rst_n = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clr_ovf  = 1'b0;
    model_reset();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);
    test_reset();
    test_single("single", 3'b101, 6'b101010);
    test_single("parity", 3'b100, 6'b111000);
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
